// File: rtl/mul_share_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul_share_ctrl                                                |
// | Purpose  : Round-robin sequencer sharing one iterative radix-4 Booth     |
// |            multiplier core between the integer MUL unit (port 0) and the |
// |            FPU mantissa multiply (port 1). Latches operands, pulses the  |
// |            core start, counts iterations, selects the product half and   |
// |            returns it on a valid/ready channel tagged with the port ID.  |
// | Options  : MUL_ZERO_BYPASS_EN - a zero operand skips the core and the    |
// |            response (0) is offered one cycle after accept.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mul_share_ctrl #(
  parameter int XLEN     = 32,
  parameter int CORE_LAT = 17,
  parameter int CNT_W    = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              kill_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [XLEN-1:0]   req0_a_i,
  input  logic [XLEN-1:0]   req0_b_i,
  input  logic              req0_high_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [XLEN-1:0]   req1_a_i,
  input  logic [XLEN-1:0]   req1_b_i,
  input  logic              req1_high_i,
  output logic              core_start_o,
  output logic [XLEN-1:0]   core_a_o,
  output logic [XLEN-1:0]   core_b_o,
  input  logic [2*XLEN-1:0] core_prod_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [XLEN-1:0]   resp_data_o,
  output logic              resp_id_o,
  output logic              busy_o
);

  // Last BUSY count: the core product is valid in this cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              rr_prio;      // port favoured on a tie (0 or 1)
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic              high_q;
  logic              id_q;
  logic [XLEN-1:0]   resp_data_q;

  logic              elig0;
  logic              elig1;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              kill_own;
  logic              zero_op;
  logic [XLEN-1:0]   sel_a;
  logic [XLEN-1:0]   sel_b;
  logic              sel_high;

  // A flush only concerns the integer pipeline, so it masks port 0 only.
  assign elig0    = req0_valid_i & ~kill_i;
  assign elig1    = req1_valid_i;
  assign kill_own = kill_i & ~id_q;

  // Grant in IDLE only; a tie goes to the port not granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (elig0 && elig1) begin
        grant0 = ~rr_prio;
        grant1 = rr_prio;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign accept   = grant0 | grant1;
  assign sel_a    = grant1 ? req1_a_i    : req0_a_i;
  assign sel_b    = grant1 ? req1_b_i    : req0_b_i;
  assign sel_high = grant1 ? req1_high_i : req0_high_i;

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (sel_a == '0) || (sel_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Next-state logic for the sequencing FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = zero_op ? RESP : ISSUE;
      ISSUE:   state_nxt = kill_own ? IDLE : BUSY;
      BUSY: begin
        if (kill_own)             state_nxt = IDLE;
        else if (cnt == CNT_LAST) state_nxt = RESP;
      end
      RESP:    if (kill_own || resp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Latch the granted request and move the round-robin pointer past it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_q     <= '0;
      b_q     <= '0;
      high_q  <= 1'b0;
      id_q    <= 1'b0;
      rr_prio <= 1'b0;
    end else if (accept) begin
      a_q     <= sel_a;
      b_q     <= sel_b;
      high_q  <= sel_high;
      id_q    <= grant1;
      rr_prio <= grant0;
    end
  end

  // Iteration counter: cleared while issuing, counts through BUSY.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)              cnt <= '0;
    else if (state == ISSUE)   cnt <= '0;
    else if (state == BUSY)    cnt <= cnt + CNT_W'(1);
  end

  // Capture the requested product half once the core result is valid.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      resp_data_q <= '0;
    end else if (state == BUSY && cnt == CNT_LAST && !kill_own) begin
      resp_data_q <= high_q ? core_prod_i[2*XLEN-1:XLEN] : core_prod_i[XLEN-1:0];
    end else if (accept && zero_op) begin
      resp_data_q <= '0;
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;
  assign core_start_o = (state == ISSUE);
  assign core_a_o     = a_q;
  assign core_b_o     = b_q;
  // A kill on the owning port withdraws the response in the same cycle.
  assign resp_valid_o = (state == RESP) & ~kill_own;
  assign resp_data_o  = resp_data_q;
  assign resp_id_o    = id_q;
  assign busy_o       = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul_share_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mul_share_ctrl                                             |
// | Purpose  : Self-checking bench for mul_share_ctrl with a transaction-    |
// |            level reference model and a behavioural multiplier core.      |
// |            Honours MUL_ZERO_BYPASS_EN when defined.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mul_share_ctrl;

  localparam int XLEN = 32;
  localparam int LAT  = 17;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic              kill_i;
  logic              req0_valid_i, req0_ready_o, req0_high_i;
  logic [XLEN-1:0]   req0_a_i, req0_b_i;
  logic              req1_valid_i, req1_ready_o, req1_high_i;
  logic [XLEN-1:0]   req1_a_i, req1_b_i;
  logic              core_start_o;
  logic [XLEN-1:0]   core_a_o, core_b_o;
  logic [2*XLEN-1:0] core_prod_i;
  logic              resp_valid_o, resp_ready_i, resp_id_o, busy_o;
  logic [XLEN-1:0]   resp_data_o;

  mul_share_ctrl #(.XLEN(XLEN), .CORE_LAT(LAT), .CNT_W(5)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .kill_i(kill_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_high_i(req0_high_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_high_i(req1_high_i),
    .core_start_o(core_start_o), .core_a_o(core_a_o), .core_b_o(core_b_o),
    .core_prod_i(core_prod_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_id_o(resp_id_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: one transaction in flight, timed from its accept cycle.
  bit          m_busy = 1'b0;
  int          m_acc  = 0;
  bit          m_id, m_high, m_zero;
  logic [31:0] m_a, m_b;
  bit          m_rr   = 1'b0;   // port favoured on a tie

  // Behavioural core: product valid LAT cycles after the start pulse.
  int          c_start = -1000;
  logic [63:0] c_prod  = '0;

  // Observations of the DUT in the last stepped cycle (stimulus control only).
  bit          obs_acc0, obs_acc1, obs_start, obs_resp, obs_rv, obs_busy, obs_id;
  logic [31:0] obs_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_res(input logic [31:0] a, input logic [31:0] b,
                                          input bit high, input bit zero);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    if (zero) return 32'h0;
    return high ? p[63:32] : p[31:0];
  endfunction

  function automatic bit is_zero_op(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_ZERO_BYPASS_EN
    return (a == 32'h0) || (b == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: compare at the falling edge, advance model, return at posedge+1.
  task automatic step();
    bit g0, g1, rv, el0, el1;
    int e, lat;
    @(negedge clk_i);
    cyc++;
    if (core_start_o) begin
      c_start = cyc;
      c_prod  = 64'(longint'($signed(core_a_o)) * longint'($signed(core_b_o)));
    end
    g0 = 1'b0; g1 = 1'b0; rv = 1'b0;
    e  = cyc - m_acc;
    if (!m_busy) begin
      el0 = req0_valid_i && !kill_i;
      el1 = req1_valid_i;
      g0  = el0 && (!el1 || !m_rr);
      g1  = el1 && (!el0 || m_rr);
      chk("ready0", 64'(req0_ready_o), 64'(g0));
      chk("ready1", 64'(req1_ready_o), 64'(g1));
      chk("busy_idle", 64'(busy_o), 64'd0);
      chk("start_idle", 64'(core_start_o), 64'd0);
      chk("rvalid_idle", 64'(resp_valid_o), 64'd0);
    end else begin
      lat = m_zero ? 1 : LAT + 2;
      rv  = (e >= lat) && !(kill_i && !m_id);
      chk("ready0_busy", 64'(req0_ready_o), 64'd0);
      chk("ready1_busy", 64'(req1_ready_o), 64'd0);
      chk("busy", 64'(busy_o), 64'd1);
      chk("start", 64'(core_start_o), 64'(!m_zero && e == 1));
      chk("rvalid", 64'(resp_valid_o), 64'(rv));
      chk("core_a", 64'(core_a_o), 64'(m_a));
      chk("core_b", 64'(core_b_o), 64'(m_b));
      if (rv) begin
        chk("rdata", 64'(resp_data_o), 64'(exp_res(m_a, m_b, m_high, m_zero)));
        chk("rid", 64'(resp_id_o), 64'(m_id));
      end
    end
    obs_acc0  = req0_valid_i && req0_ready_o;
    obs_acc1  = req1_valid_i && req1_ready_o;
    obs_start = core_start_o;
    obs_rv    = resp_valid_o;
    obs_resp  = resp_valid_o && resp_ready_i;
    obs_busy  = busy_o;
    obs_data  = resp_data_o;
    obs_id    = resp_id_o;
    if (!m_busy) begin
      if (g0 || g1) begin
        m_busy = 1'b1;
        m_acc  = cyc;
        m_id   = g1;
        m_a    = g1 ? req1_a_i : req0_a_i;
        m_b    = g1 ? req1_b_i : req0_b_i;
        m_high = g1 ? req1_high_i : req0_high_i;
        m_zero = is_zero_op(m_a, m_b);
        m_rr   = g0;
      end
    end else if (kill_i && !m_id) begin
      m_busy = 1'b0;
    end else if (rv && resp_ready_i) begin
      m_busy = 1'b0;
    end
    core_prod_i = (cyc - c_start >= LAT) ? c_prod : {$urandom(), $urandom()};
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_single(input bit port, input logic [31:0] a, input logic [31:0] b,
                           input bit high, output bit got, output int lat,
                           output logic [31:0] data, output bit id, output int starts);
    int acc_c;
    acc_c = -1; got = 1'b0; lat = -1; data = '0; id = 1'b0; starts = 0;
    resp_ready_i = 1'b1;
    if (port) begin
      req1_valid_i = 1'b1; req1_a_i = a; req1_b_i = b; req1_high_i = high;
    end else begin
      req0_valid_i = 1'b1; req0_a_i = a; req0_b_i = b; req0_high_i = high;
    end
    for (int i = 0; i < 80 && !got; i++) begin
      step();
      if (obs_acc0 || obs_acc1) begin
        acc_c = cyc; req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      end
      if (obs_start) starts++;
      if (obs_resp) begin
        got = 1'b1; lat = cyc - acc_c; data = obs_data; id = obs_id;
      end
    end
    step();
  endtask

  task automatic drain(output bit saw_resp, output bit last_id);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; kill_i = 1'b0; resp_ready_i = 1'b1;
    saw_resp = 1'b0; last_id = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (obs_resp) begin saw_resp = 1'b1; last_id = obs_id; end
      if (!obs_busy) break;
    end
    chk("drain_idle", 64'(obs_busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          got, id, saw, lid;
    int          lat, starts, nacc, held, acc1_seen;
    logic [31:0] data;
    logic [3:0]  order;

    rst_n_i = 1'b0; kill_i = 1'b0; resp_ready_i = 1'b0;
    req0_valid_i = 1'b0; req0_a_i = '0; req0_b_i = '0; req0_high_i = 1'b0;
    req1_valid_i = 1'b0; req1_a_i = '0; req1_b_i = '0; req1_high_i = 1'b0;
    core_prod_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    // Reset state
    chk("rst_ready0", 64'(req0_ready_o), 64'd0);
    chk("rst_ready1", 64'(req1_ready_o), 64'd0);
    chk("rst_start",  64'(core_start_o), 64'd0);
    chk("rst_core_a", 64'(core_a_o), 64'd0);
    chk("rst_core_b", 64'(core_b_o), 64'd0);
    chk("rst_rvalid", 64'(resp_valid_o), 64'd0);
    chk("rst_rdata",  64'(resp_data_o), 64'd0);
    chk("rst_rid",    64'(resp_id_o), 64'd0);
    chk("rst_busy",   64'(busy_o), 64'd0);
    rst_n_i = 1'b1;
    step();

    // Port 0 alone: 7 * -3, low half
    do_single(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, got, lat, data, id, starts);
    chk("t1_got", 64'(got), 64'd1);
    chk("t1_lat", 64'(lat), 64'd19);
    chk("t1_data", 64'(data), 64'hFFFF_FFEB);
    chk("t1_id", 64'(id), 64'd0);
    chk("t1_starts", 64'(starts), 64'd1);

    // Port 1 alone: 0x80000000 squared, high half
    do_single(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, got, lat, data, id, starts);
    chk("t2_got", 64'(got), 64'd1);
    chk("t2_data", 64'(data), 64'h4000_0000);
    chk("t2_id", 64'(id), 64'd1);

    // Both ports valid continuously: grants must alternate 0,1,0,1
    resp_ready_i = 1'b1;
    req0_valid_i = 1'b1; req0_a_i = $urandom(); req0_b_i = $urandom(); req0_high_i = 1'b1;
    req1_valid_i = 1'b1; req1_a_i = $urandom(); req1_b_i = $urandom(); req1_high_i = 1'b0;
    nacc = 0; order = '0;
    for (int i = 0; i < 200 && nacc < 4; i++) begin
      step();
      if (obs_acc0 || obs_acc1) begin
        order[nacc] = obs_acc1;
        nacc++;
        if (obs_acc0) begin req0_a_i = $urandom(); req0_b_i = $urandom(); end
        if (obs_acc1) begin req1_a_i = $urandom(); req1_b_i = $urandom(); end
      end
    end
    chk("t3_nacc", 64'(nacc), 64'd4);
    chk("t3_order", 64'(order), 64'b1010);
    drain(saw, lid);

    // Back-pressure: response held 10 extra cycles with a port-1 request pending
    resp_ready_i = 1'b0;
    req0_valid_i = 1'b1; req0_a_i = 32'd12345; req0_b_i = 32'd678; req0_high_i = 1'b0;
    for (int i = 0; i < 10 && !obs_acc0; i++) step();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b1; req1_a_i = 32'd9; req1_b_i = 32'd11; req1_high_i = 1'b0;
    obs_rv = 1'b0;
    for (int i = 0; i < 40 && !obs_rv; i++) step();
    chk("t4_rvalid_seen", 64'(obs_rv), 64'd1);
    held = 0; acc1_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_rv) held++;
      if (obs_acc1) acc1_seen++;
    end
    chk("t4_held", 64'(held), 64'd10);
    chk("t4_no_ready", 64'(acc1_seen), 64'd0);
    chk("t4_hold_data", 64'(obs_data), 64'd8369910);
    resp_ready_i = 1'b1;
    step();
    chk("t4_handshake", 64'(obs_resp), 64'd1);
    step();
    chk("t4_next_grant", 64'(obs_acc1), 64'd1);
    chk("t4_next_idle", 64'(obs_busy), 64'd0);
    drain(saw, lid);

    // Kill mid-BUSY on a port-0 op with a port-1 request pending
    req0_valid_i = 1'b1; req0_a_i = 32'd5; req0_b_i = 32'd6; req0_high_i = 1'b0;
    for (int i = 0; i < 10 && !obs_acc0; i++) step();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b1; req1_a_i = 32'hFFFF_FFFF; req1_b_i = 32'd2; req1_high_i = 1'b1;
    repeat (8) step();
    kill_i = 1'b1;
    step();
    chk("t5_no_resp", 64'(obs_rv), 64'd0);
    kill_i = 1'b0;
    step();
    chk("t5_grant1", 64'(obs_acc1), 64'd1);
    chk("t5_idle", 64'(obs_busy), 64'd0);
    drain(saw, lid);
    chk("t5_resp_id", 64'(lid), 64'd1);

    // Zero operand
    do_single(1'b0, 32'd0, 32'd5, 1'b0, got, lat, data, id, starts);
    chk("t6_data", 64'(data), 64'd0);
`ifdef MUL_ZERO_BYPASS_EN
    chk("t6_lat", 64'(lat), 64'd1);
    chk("t6_starts", 64'(starts), 64'd0);
`else
    chk("t6_lat", 64'(lat), 64'd19);
    chk("t6_starts", 64'(starts), 64'd1);
`endif

    // Randomized traffic with kills and response back-pressure
    for (int i = 0; i < 500; i++) begin
      if (obs_acc0 || !req0_valid_i) begin
        req0_valid_i = ($urandom_range(0, 2) != 0);
        req0_a_i     = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
        req0_b_i     = $urandom();
        req0_high_i  = $urandom_range(0, 1) == 1;
      end
      if (obs_acc1 || !req1_valid_i) begin
        req1_valid_i = ($urandom_range(0, 2) != 0);
        req1_a_i     = $urandom();
        req1_b_i     = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
        req1_high_i  = $urandom_range(0, 1) == 1;
      end
      kill_i       = ($urandom_range(0, 19) == 0);
      resp_ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    drain(saw, lid);

    // Asynchronous reset in the middle of an operation
    req0_valid_i = 1'b1; req0_a_i = 32'd77; req0_b_i = 32'd88; req0_high_i = 1'b0;
    for (int i = 0; i < 10 && !obs_acc0; i++) step();
    req0_valid_i = 1'b0;
    repeat (5) step();
    #2 rst_n_i = 1'b0;
    #1;
    chk("ar_busy", 64'(busy_o), 64'd0);
    chk("ar_core_a", 64'(core_a_o), 64'd0);
    chk("ar_core_b", 64'(core_b_o), 64'd0);
    chk("ar_rvalid", 64'(resp_valid_o), 64'd0);
    chk("ar_rdata", 64'(resp_data_o), 64'd0);
    m_busy = 1'b0; m_rr = 1'b0; c_start = -1000;
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    // Pointer back at port 0 after reset
    req0_valid_i = 1'b1; req0_a_i = 32'd3; req0_b_i = 32'd4; req0_high_i = 1'b0;
    req1_valid_i = 1'b1; req1_a_i = 32'd5; req1_b_i = 32'd6; req1_high_i = 1'b0;
    step();
    chk("ar_rr_port0", 64'(obs_acc0), 64'd1);
    req0_valid_i = 1'b0;
    drain(saw, lid);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
